// File: rtl/map_write_arbiter_pkg.sv
// Shared bomberman map definitions: tile address/state widths and write requester indices.
package map_write_arbiter_pkg;

    localparam int MAP_ADDR_WIDTH    = 10;
    localparam int MAP_MEM_WIDTH_DEF = 2;

    typedef enum logic [1:0] {
        WR_BOMB_P1 = 2'd0,
        WR_BOMB_P2 = 2'd1,
        WR_FREE_P1 = 2'd2,
        WR_FREE_P2 = 2'd3
    } wr_req_e;

endpackage

// File: rtl/map_wr_fifo.sv
// Per-requester write buffer: power-of-2 ring with occupancy count, flush and
// full-and-popped push acceptance.
module map_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Round-robin arbiter merging buffered map tile writes onto the single map_mem write port.
// Optional MAP_WR_DROP_CNT_EN adds a saturating 8-bit dropped-write counter output.
import map_write_arbiter_pkg::*;

module map_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = MAP_ADDR_WIDTH,
    parameter int DATA_WIDTH = MAP_MEM_WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                game_over,
    input  logic [NUM_REQ-1:0]                  wr_en,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic                                mem_we,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_data,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id,
    output logic                                busy,
    output logic [NUM_REQ-1:0]                  overflow
`ifdef MAP_WR_DROP_CNT_EN
    ,
    output logic [7:0]                          drop_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [NUM_REQ-1:0] w_push, w_pop, w_full, w_empty, w_drop;
    logic [EW-1:0]      w_head [NUM_REQ];
    logic [EW-1:0]      w_sel_head;
    logic [IW-1:0]      w_cand, w_grant_idx;
    logic               w_grant_valid;

    logic               r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [IW-1:0]      r_grant_id, r_rr_ptr;
    logic [NUM_REQ-1:0] r_overflow;

    assign w_push   = game_over ? '0 : wr_en;
    assign w_pop    = w_grant_valid ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_drop   = w_push & w_full & ~w_pop;
    assign busy     = |(~w_empty);
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign grant_id = r_grant_id;
    assign overflow = r_overflow;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        map_wr_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (game_over),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  ({wr_addr[g], wr_data[g]}),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );
    end

    // First non-empty head at or after rr_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = IW'((int'(r_rr_ptr) + off) % NUM_REQ);
            if (!w_grant_valid && !w_empty[w_cand] && !game_over) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
        w_sel_head = w_head[w_grant_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= '0;
        end else begin
            r_mem_we   <= w_grant_valid;
            r_overflow <= r_overflow | w_drop;
            if (w_grant_valid) begin
                r_mem_addr <= w_sel_head[EW-1:DATA_WIDTH];
                r_mem_data <= w_sel_head[DATA_WIDTH-1:0];
                r_grant_id <= w_grant_idx;
                r_rr_ptr   <= (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

`ifdef MAP_WR_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [8:0] w_drop_num, w_drop_sum;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_drop_num = w_drop_num + 9'(w_drop[i]);
        end
        w_drop_sum = {1'b0, r_drop_cnt} + w_drop_num;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: latency, round-robin order, fairness, overflow,
// game_over flush and mid-burst reset, with hand-computed expectations.
module tb_map_write_arbiter;
    import map_write_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int AW = MAP_ADDR_WIDTH;
    localparam int DW = MAP_MEM_WIDTH_DEF;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     game_over;
    logic [NR-1:0]            wr_en;
    logic [NR-1:0][AW-1:0]    wr_addr;
    logic [NR-1:0][DW-1:0]    wr_data;
    logic                     mem_we;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_data;
    logic [1:0]               grant_id;
    logic                     busy;
    logic [NR-1:0]            overflow;
`ifdef MAP_WR_DROP_CNT_EN
    logic [7:0]               drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    map_write_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_over (game_over),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .overflow  (overflow)
`ifdef MAP_WR_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int idx, input int addr, input int data);
        wr_en[idx]   = 1'b1;
        wr_addr[idx] = AW'(addr);
        wr_data[idx] = DW'(data);
    endtask

    task automatic check_beat(input string tag, input int gid, input int addr, input int data);
        check_eq({tag, "_we"},   32'(mem_we),   32'd1);
        check_eq({tag, "_gid"},  32'(grant_id), 32'(gid));
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check_eq({tag, "_data"}, 32'(mem_data), 32'(data));
    endtask

    int fair_gid  [7] = '{0, 2, 0, 0, 0, 0, 0};
    int fair_addr [7] = '{10, 50, 11, 12, 13, 14, 15};
    int fair_data [7] = '{1, 3, 2, 3, 0, 1, 2};

    initial begin
        rst_n     = 1'b0;
        game_over = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        step();
        step();
        check_eq("rst_we",   32'(mem_we),   32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_gid",  32'(grant_id), 32'd0);
        check_eq("rst_busy", 32'(busy),     32'd0);
        check_eq("rst_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Single uncontended write.
        put(int'(WR_BOMB_P1), 17, 2);
        step();
        wr_en = '0;
        check_eq("single_lat_we", 32'(mem_we), 32'd0);
        check_eq("single_busy",   32'(busy),   32'd1);
        step();
        check_beat("single", 0, 17, 2);
        check_eq("single_busy_after", 32'(busy), 32'd0);
        step();
        check_eq("single_once", 32'(mem_we),   32'd0);
        check_eq("single_hold", 32'(mem_addr), 32'd17);

        // Reset clears the held address and rr_ptr.
        rst_n = 1'b0;
        step();
        check_eq("rst2_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;

        // All four at once from rr_ptr=0.
        for (int i = 0; i < NR; i++) put(i, i + 1, i);
        step();
        wr_en = '0;
        check_eq("simul_lat_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < NR; i++) begin
            step();
            check_beat($sformatf("simul%0d", i), i, i + 1, i);
        end
        step();
        check_eq("simul_idle", 32'(mem_we),   32'd0);
        check_eq("simul_hold", 32'(grant_id), 32'd3);

        // Fairness: req0 every cycle for six cycles, req2 once.
        for (int c = 1; c <= 9; c++) begin
            wr_en = '0;
            if (c <= 6) put(int'(WR_BOMB_P1), 9 + c, c);
            if (c == 1) put(int'(WR_FREE_P1), 50, 3);
            step();
            if (c >= 2 && c <= 8) begin
                check_beat($sformatf("fair%0d", c), fair_gid[c-2], fair_addr[c-2],
                           fair_data[c-2]);
            end else begin
                check_eq($sformatf("fair_idle%0d", c), 32'(mem_we), 32'd0);
            end
        end
        wr_en = '0;

        // Overflow on req1 while 2,3,0 are served first (rr_ptr=1 on entry).
        put(0, 20, 1);
        put(2, 30, 2);
        put(3, 40, 3);
        step();
        wr_en = '0;
        put(1, 100, 0);
        step();
        check_beat("ovf_b2", 2, 30, 2);
        put(1, 101, 1);
        step();
        check_beat("ovf_b3", 3, 40, 3);
        check_eq("ovf_pre", 32'(overflow), 32'd0);
        put(1, 102, 2);
        step();
        wr_en = '0;
        check_beat("ovf_b4", 0, 20, 1);
        check_eq("ovf_flag", 32'(overflow), 32'b0010);
        step();
        check_beat("ovf_b5", 1, 100, 0);
        step();
        check_beat("ovf_b6", 1, 101, 1);
        step();
        check_eq("ovf_idle", 32'(mem_we), 32'd0);
        check_eq("ovf_busy", 32'(busy),   32'd0);
`ifdef MAP_WR_DROP_CNT_EN
        check_eq("ovf_dropcnt", 32'(drop_cnt), 32'd1);
`endif

        // game_over flush with three pending writes.
        put(0, 60, 0);
        put(1, 61, 1);
        put(2, 62, 2);
        step();
        wr_en = '0;
        check_eq("flush_busy_pre", 32'(busy), 32'd1);
        game_over = 1'b1;
        step();
        check_eq("flush_we",   32'(mem_we), 32'd0);
        check_eq("flush_busy", 32'(busy),   32'd0);
        put(3, 63, 3);
        step();
        wr_en = '0;
        check_eq("flush_ignore", 32'(busy),     32'd0);
        check_eq("flush_ovf",    32'(overflow), 32'b0010);
        game_over = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("flush_late%0d", i), 32'(mem_we), 32'd0);
        end

        // rr_ptr kept at 2 through game_over; burst then reset after two beats.
        for (int i = 0; i < NR; i++) put(i, 70 + i, i);
        step();
        wr_en = '0;
        step();
        check_beat("burst0", 2, 72, 2);
        step();
        check_beat("burst1", 3, 73, 3);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_we",   32'(mem_we),   32'd0);
        check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
        check_eq("mid_rst_data", 32'(mem_data), 32'd0);
        check_eq("mid_rst_gid",  32'(grant_id), 32'd0);
        check_eq("mid_rst_ovf",  32'(overflow), 32'd0);
        check_eq("mid_rst_busy", 32'(busy),     32'd0);
`ifdef MAP_WR_DROP_CNT_EN
        check_eq("mid_rst_dropcnt", 32'(drop_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("post_rst%0d", i), 32'(mem_we), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (idx 0 bomb P1, 1 bomb P2, 2 free P1, 3 free P2).
REQ-002 SHALL have parameter ADDR_WIDTH, default MAP_ADDR_WIDTH: map tile address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 2: map tile state width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: per-requester buffer depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1: single clock, the pixclk domain.
REQ-006 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-007 SHALL have port game_over  input  1: level; flushes and holds the arbiter idle.
REQ-008 SHALL have port wr_en  input  NUM_REQ: per-requester one-cycle write pulse.
REQ-009 SHALL have port wr_addr  input  NUM_REQ x ADDR_WIDTH: per-requester tile address.
REQ-010 SHALL have port wr_data  input  NUM_REQ x DATA_WIDTH: per-requester tile state.
REQ-011 SHALL have port mem_we  output  1: map_mem write enable, also fanned out to power_up.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH: map_mem write address.
REQ-013 SHALL have port mem_data  output  DATA_WIDTH: map_mem write data.
REQ-014 SHALL have port grant_id  output  $clog2(NUM_REQ): requester index of the current mem_we beat.
REQ-015 SHALL have port busy  output  1: high while any FIFO is non-empty.
REQ-016 SHALL have port overflow  output  NUM_REQ: sticky per-requester drop flag.

Function
REQ-017 SHALL enqueue {wr_addr[i], wr_data[i]} into FIFO i on every rising edge where wr_en[i]=1, rst_n=1 and game_over=0, provided FIFO i is not full.
REQ-018 SHALL treat FIFO i as not full when it is full and dequeued on the same edge; the enqueue is accepted.
REQ-019 SHALL drop a write to a full, non-dequeued FIFO i and set overflow[i]; overflow[i] clears only on reset.
REQ-020 SHALL arbitrate round-robin among non-empty FIFO heads each cycle; search starts at rr_ptr; after a grant to k, rr_ptr becomes (k+1) mod NUM_REQ.
REQ-021 SHALL register the granted head onto mem_we=1, mem_addr, mem_data and grant_id on the edge following selection, and dequeue it on that edge.
REQ-022 SHALL give a latency of 2 edges from wr_en sampling to mem_we high for an uncontended write; throughput is 1 write per cycle aggregate.
REQ-023 SHALL drive mem_we=0 in any cycle with no grant; mem_addr, mem_data and grant_id then hold their last values.
REQ-024 SHALL preserve per-requester write order; no ordering is guaranteed across requesters.
REQ-025 SHALL, while game_over=1, empty all FIFOs, force mem_we=0, ignore wr_en, and keep rr_ptr and overflow unchanged.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with an occupancy counter distinguishing full from empty.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, empty all FIFOs, set rr_ptr=0, mem_we=0, mem_addr=0, mem_data=0, grant_id=0 and overflow=0; busy reads 0 from the next cycle.
REQ-028 SHALL abort in-flight writes when reset is asserted mid-operation, with no mem_we pulse emitted from the reset edge onward.

Configuration
REQ-029 SHALL, when macro MAP_WR_DROP_CNT_EN is defined, add output drop_cnt (8 bits): total dropped writes, saturating at 255, cleared by reset only, held during game_over.
REQ-030 SHALL, without MAP_WR_DROP_CNT_EN, omit the drop_cnt port and its logic; all other behaviour is identical.

Structure
REQ-031 SHALL take MAP_ADDR_WIDTH, MAP_MEM_WIDTH_DEF and a requester-index typedef (WR_BOMB_P1..WR_FREE_P2) from the shared bomberman package/header; the arbiter defines no local copies.
REQ-032 SHALL implement each buffer as sub-module map_wr_fifo (push, pop, flush, full, empty, head data), instantiated NUM_REQ times.

Verification
REQ-033 Single write: wr_en[0]=1 addr=17 data=2 at edge E -> mem_we=1, mem_addr=17, mem_data=2, grant_id=0 after edge E+2; exactly one beat.
REQ-034 Simultaneous writes: wr_en=4'b1111 (addr 1,2,3,4) in one cycle, rr_ptr=0 -> four consecutive beats, grant_id 0,1,2,3, then mem_we=0.
REQ-035 Fairness: req 0 pulses every cycle and req 2 pulses once -> req 2 is granted within 2 beats; grant_id alternates 0,2.
REQ-036 Overflow: 3 back-to-back pulses on req 1 while reqs 0,2,3 keep FIFOs non-empty, depth 2 -> overflow[1]=1 and exactly the first 2 writes appear; drop_cnt=1 when MAP_WR_DROP_CNT_EN is defined.
REQ-037 Flush: game_over=1 with 3 pending writes -> mem_we=0 from the next cycle, busy=0, no late beats after game_over falls.
REQ-038 Reset mid-burst: rst_n=0 for one edge during a 4-beat burst -> all outputs at reset values and no further mem_we.
